// File: rtl/mem_responder.sv
// Memory-side responder: word RAM serving core read/write requests
// with a fixed LATENCY and a one-cycle mem_ready completion pulse.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (RAM is retained)
//   addr      in   byte address; word index = addr[ADDR_W+1:2]
//   data_in   in   write data
//   mem_wr    in   write request (level); wins over mem_re
//   mem_re    in   read request (level)
//   data_out  out  read data, held until the next read completes
//   mem_ready out  one-cycle completion pulse per accepted request
//
// INIT_FILE names an image that the environment loads into the RAM
// array; the controller itself never clears or initialises it.
module mem_responder #(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        mem_wr,
  input  logic        mem_re,
  output logic [31:0] data_out,
  output logic        mem_ready
);

  localparam int CW    = $clog2(LATENCY) + 1;
  localparam int WORDS = 2 ** ADDR_W;

  localparam string unused_init = INIT_FILE;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt, cnt_nxt;
  logic [31:0]       ram [WORDS];

  logic [ADDR_W-1:0] lat_word;
  logic              lat_oor;
  logic              lat_wr;
  logic [31:0]       lat_data;

  logic              accept;
  logic              access;

  logic              in_idle;
  logic [ADDR_W-1:0] acc_word;
  logic              acc_oor;
  logic              acc_wr;
  logic [31:0]       acc_data;

  logic [ADDR_W-1:0] req_word;
  logic              req_oor;

  logic              unused_addr;

  assign unused_addr = ^addr[1:0];

  assign req_word = addr[ADDR_W+1:2];
  assign req_oor  = |addr[31:ADDR_W+2];

  // With LATENCY==1 the access happens at the accepting edge, so the
  // live request is used; otherwise the latched copy is.
  assign in_idle  = (state == IDLE);
  assign acc_word = in_idle ? req_word : lat_word;
  assign acc_oor  = in_idle ? req_oor  : lat_oor;
  assign acc_wr   = in_idle ? mem_wr   : lat_wr;
  assign acc_data = in_idle ? data_in  : lat_data;

  assign mem_ready = (state == DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_re | mem_wr) begin
          accept  = 1'b1;
          cnt_nxt = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            access    = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_word <= '0;
      lat_oor  <= 1'b0;
      lat_wr   <= 1'b0;
      lat_data <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_word <= req_word;
        lat_oor  <= req_oor;
        lat_wr   <= mem_wr;
        lat_data <= data_in;
      end
      if (access && !acc_wr) begin
        data_out <= acc_oor ? 32'h0 : ram[acc_word];
      end
    end
  end

  // RAM has no reset; a held reset blocks any commit.
  always_ff @(posedge clk) begin
    if (access && acc_wr && !acc_oor && !rst) begin
      ram[acc_word] <= acc_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=4 and LATENCY=1 instances,
// read expectations queued at issue and popped on mem_ready.
module tb_mem_responder;

  logic        clk;
  logic        rst;

  logic [31:0] addr4, din4, dout4;
  logic        wr4, re4, rdy4;

  logic [31:0] addr1, din1, dout1;
  logic        wr1, re1, rdy1;

  int checks;
  int failures;

  logic [31:0] exp_q[$];

  mem_responder #(
    .ADDR_W(10),
    .LATENCY(4),
    .INIT_FILE("")
  ) u4 (
    .clk(clk),
    .rst(rst),
    .addr(addr4),
    .data_in(din4),
    .mem_wr(wr4),
    .mem_re(re4),
    .data_out(dout4),
    .mem_ready(rdy4)
  );

  mem_responder #(
    .ADDR_W(10),
    .LATENCY(1),
    .INIT_FILE("")
  ) u1 (
    .clk(clk),
    .rst(rst),
    .addr(addr1),
    .data_in(din1),
    .mem_wr(wr1),
    .mem_re(re1),
    .data_out(dout1),
    .mem_ready(rdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on u4, drop it once accepted, wait for ready.
  // cyc = negedges from issue until ready seen (LATENCY+1 expected).
  task automatic req4(input logic wr, input logic re,
                      input logic [31:0] a, input logic [31:0] d,
                      output int cyc, output logic [31:0] dout);
    logic rdy;
    @(negedge clk);
    wr4 = wr; re4 = re; addr4 = a; din4 = d;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        wr4 = 1'b0;
        re4 = 1'b0;
      end
      rdy = rdy4;
    end
    dout = dout4;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL req4_timeout addr=%h", a);
    end
  endtask

  task automatic req1(input logic wr, input logic re,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] dout);
    logic rdy;
    int cyc;
    @(negedge clk);
    wr1 = wr; re1 = re; addr1 = a; din1 = d;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
      wr1 = 1'b0;
      re1 = 1'b0;
      if (rdy1) rdy = 1'b1;
    end
    dout = dout1;
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL req1_timeout addr=%h", a);
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [31:0] d, e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rdy4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0", rdy4);
    end
    checks++;
    if (dout4 !== 32'h0 || dout1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_dout got=%h/%h want=0", dout4, dout1);
    end
    rst = 1'b0;
    req4(1'b1, 1'b0, 32'h40, 32'h11111111, cyc, d);
    exp_q.push_back(32'h11111111);
    req4(1'b0, 1'b1, 32'h40, 32'h0, cyc, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++;
      $display("FAIL pre_reset_read got=%h want=%h", d, e);
    end
    @(negedge clk);
    wr4 = 1'b1; addr4 = 32'h40; din4 = 32'h22222222;
    @(negedge clk);
    wr4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rdy4 !== 1'b0) begin
      failures++;
      $display("FAIL midbusy_reset_ready got=%b want=0", rdy4);
    end
    checks++;
    if (dout4 !== 32'h0) begin
      failures++;
      $display("FAIL midbusy_reset_dout got=%h want=0", dout4);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h11111111);
    req4(1'b0, 1'b1, 32'h40, 32'h0, cyc, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++;
      $display("FAIL reset_no_commit got=%h want=%h", d, e);
    end
  endtask

  task automatic test_write_read();
    int cyc;
    logic [31:0] d, e;
    req4(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, cyc, d);
    checks++;
    if (cyc !== 5) begin
      failures++;
      $display("FAIL write_latency got=%0d want=5", cyc);
    end
    @(negedge clk);
    checks++;
    if (rdy4 !== 1'b0) begin
      failures++;
      $display("FAIL ready_one_cycle got=%b want=0", rdy4);
    end
    exp_q.push_back(32'hDEADBEEF);
    req4(1'b0, 1'b1, 32'h100, 32'h0, cyc, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++;
      $display("FAIL read_back got=%h want=%h", d, e);
    end
    checks++;
    if (cyc !== 5) begin
      failures++;
      $display("FAIL read_latency got=%0d want=5", cyc);
    end
  endtask

  task automatic test_both_high();
    int cyc;
    logic [31:0] d, e;
    exp_q.push_back(32'h11111111);
    req4(1'b0, 1'b1, 32'h40, 32'h0, cyc, d);
    e = exp_q.pop_front();
    req4(1'b1, 1'b1, 32'h8, 32'h12345678, cyc, d);
    checks++;
    if (d !== e) begin
      failures++;
      $display("FAIL both_dout_kept got=%h want=%h", d, e);
    end
    exp_q.push_back(32'h12345678);
    req4(1'b0, 1'b1, 32'h8, 32'h0, cyc, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++;
      $display("FAIL both_written got=%h want=%h", d, e);
    end
  endtask

  task automatic test_mid_busy();
    int cyc;
    int pulses;
    logic [31:0] d, e;
    req4(1'b1, 1'b0, 32'h10, 32'hA0A0A0A0, cyc, d);
    req4(1'b1, 1'b0, 32'h20, 32'hB0B0B0B0, cyc, d);
    exp_q.push_back(32'hA0A0A0A0);
    @(negedge clk);
    re4 = 1'b1; addr4 = 32'h10;
    @(negedge clk);
    re4 = 1'b0; addr4 = 32'h20;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy4) begin
        pulses++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (dout4 !== e) begin
            failures++;
            $display("FAIL midbusy_data got=%h want=%h", dout4, e);
          end
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL midbusy_pulses got=%0d want=1", pulses);
    end
    exp_q.delete();
  endtask

  task automatic test_out_of_range();
    int cyc;
    logic [31:0] d, e;
    req4(1'b1, 1'b0, 32'h0, 32'h0BADF00D, cyc, d);
    req4(1'b1, 1'b0, 32'h1000, 32'hAAAA5555, cyc, d);
    checks++;
    if (cyc !== 5) begin
      failures++;
      $display("FAIL oor_write_ready got=%0d want=5", cyc);
    end
    exp_q.push_back(32'h0);
    req4(1'b0, 1'b1, 32'h1000, 32'h0, cyc, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++;
      $display("FAIL oor_read got=%h want=%h", d, e);
    end
    exp_q.push_back(32'h0BADF00D);
    req4(1'b0, 1'b1, 32'h0, 32'h0, cyc, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      failures++;
      $display("FAIL oor_no_alias got=%h want=%h", d, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    int first, second, pulses;
    req1(1'b1, 1'b0, 32'h0, 32'hCAFE0000, d);
    req1(1'b1, 1'b0, 32'h4, 32'hCAFE0004, d);
    exp_q.push_back(32'hCAFE0000);
    exp_q.push_back(32'hCAFE0004);
    @(negedge clk);
    re1 = 1'b1; addr1 = 32'h0;
    pulses = 0; first = -1; second = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rdy1) begin
        pulses++;
        if (pulses == 1) first = i;
        if (pulses == 2) second = i;
        addr1 = 32'h4;
        if (pulses >= 2) re1 = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (dout1 !== e) begin
            failures++;
            $display("FAIL b2b_data%0d got=%h want=%h",
                     pulses, dout1, e);
          end
        end
      end
    end
    re1 = 1'b0;
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d want=2", pulses);
    end
    checks++;
    if (second - first !== 2) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d want=2", second - first);
    end
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    addr4 = '0; din4 = '0; wr4 = 1'b0; re4 = 1'b0;
    addr1 = '0; din1 = '0; wr1 = 1'b0; re1 = 1'b0;
    test_reset();
    test_write_read();
    test_both_high();
    test_mid_busy();
    test_out_of_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
